// File: rtl/id_pkg.sv
// Shared constants and types for the decode/operand stage: widths, the opcodes
// whose second source is the rd field, and the resolved-operand record.
package id_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_GRP_0A = 6'h0A;
    localparam logic [5:0] OP_ST_LO  = 6'h16;
    localparam logic [5:0] OP_ST_HI  = 6'h1B;

    localparam logic [3:0] SUB_ST_B = 4'd4;
    localparam logic [3:0] SUB_ST_H = 4'd5;
    localparam logic [3:0] SUB_ST_W = 4'd6;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } iq_entry_t;

    typedef struct packed {
        logic [XLEN-1:0] value;
        logic            blocked;
    } operand_t;

    // Stores and store-like 0x0A sub-ops read their data register from rd, not rk.
    function automatic logic src2_is_rd(input logic [XLEN-1:0] inst);
        logic [5:0] op;
        logic [3:0] sub;
        logic       res;
        op  = inst[31:26];
        sub = inst[25:22];
        res = 1'b0;
        if ((op >= OP_ST_LO) && (op <= OP_ST_HI)) begin
            res = 1'b1;
        end else if (op == OP_GRP_0A) begin
            case (sub)
                SUB_ST_B, SUB_ST_H, SUB_ST_W: res = 1'b1;
                default:                      res = 1'b0;
            endcase
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/iq_fifo.sv
// Circular instruction queue with occupancy count; clear wins over push and pop.
module iq_fifo
    import id_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok_s, pop_ok_s;

    assign push_ok_s = push && (count_q != CNT_FULL);
    assign pop_ok_s  = pop  && (count_q != '0);

    // Pointer and occupancy next-state; power-of-two depth makes wrap free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care once the count says empty.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clear) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

endmodule

// File: rtl/id_operand_stage.sv
// Decode operand stage: queues fetched instructions, reads/forwards both source
// operands for the head, stalls on not-ready producers and stages the result.
module id_operand_stage
    import id_pkg::*;
#(
    parameter int IQ_DEPTH = 4,
    parameter int NUM_FWD  = 3
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       fd_valid,
    input  logic [XLEN-1:0]            fd_pc,
    input  logic [XLEN-1:0]            fd_inst,
    output logic                       d_allowin,
    input  logic                       flush,
    output logic [REG_AW-1:0]          rf_raddr1,
    output logic [REG_AW-1:0]          rf_raddr2,
    input  logic [XLEN-1:0]            rf_rdata1,
    input  logic [XLEN-1:0]            rf_rdata2,
    input  logic [NUM_FWD-1:0]         fwd_valid,
    input  logic [NUM_FWD-1:0]         fwd_ready,
    input  logic [REG_AW*NUM_FWD-1:0]  fwd_dest,
    input  logic [XLEN*NUM_FWD-1:0]    fwd_data,
    input  logic                       e_allowin,
    output logic                       de_valid,
    output logic [XLEN-1:0]            de_pc,
    output logic [XLEN-1:0]            de_inst,
    output logic [XLEN-1:0]            de_rj_value,
    output logic [XLEN-1:0]            de_rkd_value,
    output logic [XLEN-1:0]            stall_cnt
);

    localparam int CW = $clog2(IQ_DEPTH) + 1;
    localparam logic [CW-1:0]   CNT_FULL = CW'(IQ_DEPTH);
    localparam logic [XLEN-1:0] CNT_MAX  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] CNT_INC  = XLEN'(1);

    logic [CW-1:0]   iq_count_s;
    iq_entry_t       head_s;
    iq_entry_t       push_entry_s;
    logic            head_valid_s;
    logic            push_s, pop_s, issue_s, hazard_s;
    operand_t        src1_s, src2_s;

    logic            de_valid_q, de_valid_d;
    logic [XLEN-1:0] de_pc_q, de_inst_q, de_rj_q, de_rkd_q;
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;

    // Lowest-index matching channel wins even when it is not ready; r0 is hardwired zero.
    function automatic operand_t resolve_src(
        input logic [REG_AW-1:0]         addr,
        input logic [XLEN-1:0]           rf_val,
        input logic [NUM_FWD-1:0]        valid,
        input logic [NUM_FWD-1:0]        ready,
        input logic [REG_AW*NUM_FWD-1:0] dest,
        input logic [XLEN*NUM_FWD-1:0]   data
    );
        operand_t res;
        logic     hit;
        res.value   = rf_val;
        res.blocked = 1'b0;
        hit         = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (!hit && valid[i] && (dest[i*REG_AW +: REG_AW] == addr)) begin
                hit         = 1'b1;
                res.value   = data[i*XLEN +: XLEN];
                res.blocked = !ready[i];
            end else begin
                hit = hit;
            end
        end
        if (addr == '0) begin
            res.value   = '0;
            res.blocked = 1'b0;
        end else begin
            res = res;
        end
        return res;
    endfunction

    assign push_entry_s.pc   = fd_pc;
    assign push_entry_s.inst = fd_inst;

    iq_fifo #(
        .DEPTH (IQ_DEPTH),
        .WIDTH ($bits(iq_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clear (flush),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (push_entry_s),
        .count (iq_count_s),
        .rdata (head_s)
    );

    assign d_allowin    = (iq_count_s != CNT_FULL);
    assign head_valid_s = (iq_count_s != '0);
    assign rf_raddr1    = head_s.inst[9:5];
    assign rf_raddr2    = src2_is_rd(head_s.inst) ? head_s.inst[4:0] : head_s.inst[14:10];

    assign src1_s = resolve_src(rf_raddr1, rf_rdata1, fwd_valid, fwd_ready, fwd_dest, fwd_data);
    assign src2_s = resolve_src(rf_raddr2, rf_rdata2, fwd_valid, fwd_ready, fwd_dest, fwd_data);

    assign hazard_s = head_valid_s && (src1_s.blocked || src2_s.blocked);
    assign issue_s  = head_valid_s && !hazard_s && (!de_valid_q || e_allowin);
    assign push_s   = fd_valid && d_allowin && !flush;
    assign pop_s    = issue_s && !flush;

    // Staging-register valid and stall counter next-state; flush kills everything in flight.
    always_comb begin
        de_valid_d  = de_valid_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            de_valid_d = 1'b0;
        end else if (issue_s) begin
            de_valid_d = 1'b1;
        end else if (de_valid_q && e_allowin) begin
            de_valid_d = 1'b0;
        end else begin
            de_valid_d = de_valid_q;
        end
        if (hazard_s && !flush && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_INC;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Output staging register and stall counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            de_valid_q  <= 1'b0;
            de_pc_q     <= '0;
            de_inst_q   <= '0;
            de_rj_q     <= '0;
            de_rkd_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            de_valid_q  <= de_valid_d;
            stall_cnt_q <= stall_cnt_d;
            if (pop_s) begin
                de_pc_q   <= head_s.pc;
                de_inst_q <= head_s.inst;
                de_rj_q   <= src1_s.value;
                de_rkd_q  <= src2_s.value;
            end
        end
    end

    assign de_valid     = de_valid_q;
    assign de_pc        = de_pc_q;
    assign de_inst      = de_inst_q;
    assign de_rj_value  = de_rj_q;
    assign de_rkd_value = de_rkd_q;
    assign stall_cnt    = stall_cnt_q;

endmodule
